hist_eq_divider: RTL

Sequential, parametrised mapping divider for the histogram-equalisation pipeline. It computes g = floor((cdf_in − cdf_min) · (2^PIX_W − 1) / (total − cdf_min)) with a restoring shift-subtract divider that produces one quotient bit per clock. It sits between the CDF accumulator and the pixel remap stage, and uses valid/ready handshakes on both sides. Unlike the fixed-constant divider it replaces, cdf_min and total are run-time inputs, and the block handles saturation and divide-by-zero.

---
 rtl/hist_eq_divider_if.sv | 26 ++
 rtl/hist_eq_divider.sv | 112 +++++++++++
 2 files changed

// File: rtl/hist_eq_divider_if.sv
// Handshake bundle between the CDF accumulator, the mapping divider and the pixel remap stage.
interface hist_eq_divider_if #(
  parameter int CDF_W = 16,
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [CDF_W-1:0] cdf_in;
  logic [CDF_W-1:0] cdf_min;
  logic [CDF_W-1:0] total;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] g_out;
  logic             sat;
  logic             div_zero;

  modport slave (
    input  in_valid, cdf_in, cdf_min, total, out_ready,
    output in_ready, out_valid, g_out, sat, div_zero
  );

  modport master (
    output in_valid, cdf_in, cdf_min, total, out_ready,
    input  in_ready, out_valid, g_out, sat, div_zero
  );
endinterface

// File: rtl/hist_eq_divider.sv
// Histogram-equalisation mapping divider: g = floor((cdf_in-cdf_min)*(2^PIX_W-1)/(total-cdf_min)),
// one quotient bit per clock via restoring shift-subtract, with saturation and divide-by-zero handling.
module hist_eq_divider #(
  parameter int CDF_W = 16,
  parameter int PIX_W = 8
) (
  input  logic clk,
  input  logic reset,
  hist_eq_divider_if.slave bus
);
  localparam int NUM_W = CDF_W + PIX_W;
  localparam int CNT_W = $clog2(NUM_W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NUM_W:0]   r_rem;
  logic [NUM_W-1:0] r_quo;
  logic [CDF_W-1:0] r_den;
  logic [CNT_W-1:0] r_cnt;
  logic [PIX_W-1:0] r_g;
  logic             r_sat;
  logic             r_dz;

  logic             w_capture;
  logic             w_fast;
  logic [CDF_W-1:0] w_diff;
  logic [CDF_W-1:0] w_den;
  logic [NUM_W-1:0] w_num;
  logic [NUM_W+1:0] w_shift;
  logic [NUM_W:0]   w_trial;
  logic             w_ge;
  logic [NUM_W-1:0] w_quo_nxt;
  logic             w_overflow;
  logic             w_last;

  assign bus.in_ready  = (r_state == IDLE) && !reset;
  assign bus.out_valid = (r_state == DONE);
  assign bus.g_out     = r_g;
  assign bus.sat       = r_sat;
  assign bus.div_zero  = r_dz;

  assign w_capture = bus.in_valid && bus.in_ready;
  assign w_fast    = (bus.cdf_in < bus.cdf_min) || (bus.total <= bus.cdf_min);
  assign w_diff    = bus.cdf_in - bus.cdf_min;
  assign w_den     = bus.total - bus.cdf_min;
  // diff*(2^PIX_W-1) as a shift and subtract; NUM_W bits hold it exactly
  assign w_num     = ({{PIX_W{1'b0}}, w_diff} << PIX_W) - {{PIX_W{1'b0}}, w_diff};

  assign w_shift    = {r_rem, r_quo[NUM_W-1]};
  assign w_ge       = w_shift >= {{(NUM_W+2-CDF_W){1'b0}}, r_den};
  assign w_trial    = w_shift[NUM_W:0] - {{(NUM_W+1-CDF_W){1'b0}}, r_den};
  assign w_quo_nxt  = {r_quo[NUM_W-2:0], w_ge};
  assign w_overflow = |w_quo_nxt[NUM_W-1:PIX_W];
  assign w_last     = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_capture) w_state_nxt = w_fast ? DONE : CALC;
      CALC: if (w_last) w_state_nxt = DONE;
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_den <= '0;
      r_cnt <= '0;
      r_g   <= '0;
      r_sat <= 1'b0;
      r_dz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            if (w_fast) begin
              r_g   <= '0;
              r_sat <= 1'b0;
              r_dz  <= (bus.total == bus.cdf_min);
            end else begin
              r_rem <= '0;
              r_quo <= w_num;
              r_den <= w_den;
              r_cnt <= CNT_W'(NUM_W - 1);
            end
          end
        end
        CALC: begin
          r_rem <= w_ge ? w_trial : w_shift[NUM_W:0];
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (w_last) begin
            r_g   <= w_overflow ? {PIX_W{1'b1}} : w_quo_nxt[PIX_W-1:0];
            r_sat <= w_overflow;
            r_dz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
